rf_write_arbiter: RTL and testbench

Round-robin arbiter that shares the N_WRITE write ports of the physical register file, and of its bypass read buffer, among N_REQ writeback requesters such as ALUs, the LSU and the multiplier. Each requester presents a valid/ready handshake. The arbiter grants up to N_WRITE requests per cycle and removes same-cycle same-address collisions. It drives registered write-port signals (wen/waddr/wdata) into the register file.

---
 rtl/rf_write_arbiter.sv | 104 ++++++++++
 tb/tb_rf_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter for the register file: grants up to N_WRITE
// requesters per cycle, drops r0 writes, and resolves same-cycle address clashes.
module rf_write_arbiter #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int N_REQ   = 4,
  parameter int N_WRITE = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0]          req_data,
  output logic [N_REQ-1:0]                     req_ready,
  output logic [N_WRITE-1:0]                   wen,
  output logic [N_WRITE-1:0][ADDR_WIDTH-1:0]   waddr,
  output logic [N_WRITE-1:0][WIDTH-1:0]        wdata
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] NREQ_S = SUM_W'(N_REQ);

  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [N_WRITE-1:0]                 wen_q, wen_d;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [N_WRITE-1:0][WIDTH-1:0]      wdata_q, wdata_d;

  logic [N_REQ-1:0] ready_c;
  logic [SUM_W-1:0] scan_sum;
  logic [PTR_W-1:0] scan_idx, last_idx;
  logic             any_acc, conflict, placed;

  // Scan from ptr with wrap; the port set built so far doubles as the
  // collision table, and ports always fill as a prefix from index 0.
  always_comb begin
    ready_c  = '0;
    wen_d    = '0;
    waddr_d  = '0;
    wdata_d  = '0;
    any_acc  = 1'b0;
    last_idx = '0;
    scan_sum = '0;
    scan_idx = '0;
    conflict = 1'b0;
    placed   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      scan_sum = {1'b0, ptr_q} + SUM_W'(j);
      if (scan_sum >= NREQ_S) scan_sum = scan_sum - NREQ_S;
      scan_idx = scan_sum[PTR_W-1:0];
      if (req_valid[scan_idx]) begin
        if (req_addr[scan_idx] == '0) begin
          ready_c[scan_idx] = 1'b1;
          any_acc           = 1'b1;
          last_idx          = scan_idx;
        end else begin
          conflict = 1'b0;
          for (int k = 0; k < N_WRITE; k++)
            if (wen_d[k] && (waddr_d[k] == req_addr[scan_idx])) conflict = 1'b1;
          placed = 1'b0;
          if (!conflict) begin
            for (int k = 0; k < N_WRITE; k++) begin
              if (!placed && !wen_d[k]) begin
                wen_d[k]   = 1'b1;
                waddr_d[k] = req_addr[scan_idx];
                wdata_d[k] = req_data[scan_idx];
                placed     = 1'b1;
              end
            end
          end
          if (placed) begin
            ready_c[scan_idx] = 1'b1;
            any_acc           = 1'b1;
            last_idx          = scan_idx;
          end
        end
      end
    end
    scan_sum = {1'b0, last_idx} + SUM_W'(1);
    if (scan_sum >= NREQ_S) scan_sum = scan_sum - NREQ_S;
    ptr_d = any_acc ? scan_sum[PTR_W-1:0] : ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready = resetn ? ready_c : '0;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scenario bench for rf_write_arbiter (N_REQ=4, N_WRITE=2): ready is checked
// combinationally, expected port writes go through a queue and pop after the edge.
module tb_rf_write_arbiter;

  logic             clk;
  logic             resetn;
  logic [3:0]       req_valid;
  logic [3:0][4:0]  req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [1:0]       wen;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;

  typedef struct {
    string            name;
    logic [1:0]       wen;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  rf_write_arbiter #(.WIDTH(32), .DEPTH(32), .N_REQ(4), .N_WRITE(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] dat(input int i, input logic [31:0] salt);
    return (32'(i + 1) * 32'h1000_0000) + salt;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [4:0] a3, input logic [4:0] a2,
                       input logic [4:0] a1, input logic [4:0] a0, input logic [31:0] salt);
    req_valid   = v;
    req_addr[3] = a3;
    req_addr[2] = a2;
    req_addr[1] = a1;
    req_addr[0] = a0;
    for (int i = 0; i < 4; i++) req_data[i] = dat(i, salt);
  endtask

  task automatic push_exp(input string n, input logic [1:0] w,
                          input logic [1:0][4:0] a, input logic [1:0][31:0] d);
    exp_t t;
    t.name  = n;
    t.wen   = w;
    t.waddr = a;
    t.wdata = d;
    sbq.push_back(t);
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    drive(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    #2 resetn = 1'b0;
    drive(4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, 32'h0);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL rst_ready: ready=%b want=%b", req_ready, 4'b0000);
    end
    checks++;
    if (wen !== 2'b00 || waddr !== '0 || wdata !== '0) begin
      failures++; $display("FAIL rst_out: wen=%b waddr=%h wdata=%h want all zero", wen, waddr, wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || wen !== 2'b00 || waddr !== '0 || wdata !== '0) begin
      failures++; $display("FAIL rst_held: ready=%b wen=%b waddr=%h wdata=%h want all zero", req_ready, wen, waddr, wdata);
    end
    @(negedge clk) resetn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0011) begin
      failures++; $display("FAIL rst_first_grant: ready=%b want=%b", req_ready, 4'b0011);
    end
    drive(4'b0000, 5'd4, 5'd3, 5'd2, 5'd1, 32'h0);
    push_exp("rst_idle", 2'b00, '0, '0);
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
  endtask

  task automatic test_full_load();
    logic [31:0] s = 32'h100;
    drive(4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, s);
    #1; checks++;
    if (req_ready !== 4'b0011) begin
      failures++; $display("FAIL full_ready0: ready=%b want=%b", req_ready, 4'b0011);
    end
    push_exp("full_out0", 2'b11, {5'd2, 5'd1}, {dat(1, s), dat(0, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    drive(4'b1100, 5'd4, 5'd3, 5'd2, 5'd1, s);
    #1; checks++;
    if (req_ready !== 4'b1100) begin
      failures++; $display("FAIL full_ready1: ready=%b want=%b", req_ready, 4'b1100);
    end
    push_exp("full_out1", 2'b11, {5'd4, 5'd3}, {dat(3, s), dat(2, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    drive(4'b0000, 5'd4, 5'd3, 5'd2, 5'd1, s);
    #1; checks++;
    if (req_ready !== 4'b0000) begin
      failures++; $display("FAIL full_ready2: ready=%b want=%b", req_ready, 4'b0000);
    end
    push_exp("full_idle", 2'b00, '0, '0);
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] s = 32'h200;
    drive(4'b0111, 5'd15, 5'd6, 5'd5, 5'd5, s);
    #1; checks++;
    if (req_ready !== 4'b0101) begin
      failures++; $display("FAIL conf_ready0: ready=%b want=%b", req_ready, 4'b0101);
    end
    push_exp("conf_out0", 2'b11, {5'd6, 5'd5}, {dat(2, s), dat(0, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    drive(4'b0010, 5'd15, 5'd6, 5'd5, 5'd5, s);
    #1; checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL conf_ready1: ready=%b want=%b", req_ready, 4'b0010);
    end
    push_exp("conf_retry", 2'b01, {5'd0, 5'd5}, {32'h0, dat(1, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    // ptr is now 2; a lone req3 moves it back to 0
    drive(4'b1000, 5'd10, 5'd6, 5'd5, 5'd5, s);
    #1; checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL conf_ready2: ready=%b want=%b", req_ready, 4'b1000);
    end
    push_exp("conf_single", 2'b01, {5'd0, 5'd10}, {32'h0, dat(3, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
  endtask

  task automatic test_zero_addr();
    logic [31:0] s = 32'h300;
    drive(4'b1111, 5'd7, 5'd6, 5'd0, 5'd4, s);
    #1; checks++;
    if (req_ready !== 4'b0111) begin
      failures++; $display("FAIL zero_ready: ready=%b want=%b", req_ready, 4'b0111);
    end
    push_exp("zero_out", 2'b11, {5'd6, 5'd4}, {dat(2, s), dat(0, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] s = 32'h400;
    drive(4'b1001, 5'd9, 5'd2, 5'd1, 5'd8, s);
    #1; checks++;
    if (req_ready !== 4'b1001) begin
      failures++; $display("FAIL wrap_ready: ready=%b want=%b", req_ready, 4'b1001);
    end
    push_exp("wrap_out", 2'b11, {5'd8, 5'd9}, {dat(0, s), dat(3, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    // ptr=1: only r0 writes, accepted without a port, ptr moves to 3
    drive(4'b0110, 5'd9, 5'd0, 5'd0, 5'd8, s);
    #1; checks++;
    if (req_ready !== 4'b0110) begin
      failures++; $display("FAIL allzero_ready: ready=%b want=%b", req_ready, 4'b0110);
    end
    push_exp("allzero_out", 2'b00, '0, '0);
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    drive(4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, s);
    #1; checks++;
    if (req_ready !== 4'b1001) begin
      failures++; $display("FAIL allzero_ptr: ready=%b want=%b", req_ready, 4'b1001);
    end
    push_exp("allzero_next", 2'b11, {5'd1, 5'd4}, {dat(0, s), dat(3, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] s = 32'h500;
    drive(4'b1111, 5'd4, 5'd3, 5'd2, 5'd1, s);
    #1; checks++;
    if (req_ready !== 4'b0110) begin
      failures++; $display("FAIL arst_ready0: ready=%b want=%b", req_ready, 4'b0110);
    end
    push_exp("arst_out0", 2'b11, {5'd3, 5'd2}, {dat(2, s), dat(1, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    #1; checks++;
    if (req_ready !== 4'b1001) begin
      failures++; $display("FAIL arst_ready1: ready=%b want=%b", req_ready, 4'b1001);
    end
    #1 resetn = 1'b0;
    #1; checks++;
    if (wen !== 2'b00 || waddr !== '0 || wdata !== '0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL arst_immediate: wen=%b waddr=%h wdata=%h ready=%b want all zero", wen, waddr, wdata, req_ready);
    end
    @(negedge clk) resetn = 1'b1;
    #1; checks++;
    if (req_ready !== 4'b0011) begin
      failures++; $display("FAIL arst_ptr0: ready=%b want=%b", req_ready, 4'b0011);
    end
    push_exp("arst_after", 2'b11, {5'd2, 5'd1}, {dat(1, s), dat(0, s)});
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (wen !== e.wen || waddr !== e.waddr || wdata !== e.wdata) begin
      failures++; $display("FAIL %s: got wen=%b waddr=%h wdata=%h want wen=%b waddr=%h wdata=%h", e.name, wen, waddr, wdata, e.wen, e.waddr, e.wdata);
    end
    drive(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, s);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_conflict();
    test_zero_addr();
    test_wrap();
    test_async_reset();
    checks++;
    if (sbq.size() != 0) begin
      failures++; $display("FAIL sb_drain: entries=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
